fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Fetch-stage controller that sequences the ProgramCounter register.
//  Drives next_inst_address, which ProgramCounter loads on every posedge clock.
//  Arbitrates PC sources: reset vector, jump, branch, stall, imem wait and PC+4.
//  Handshakes with instruction memory and flags fetch timeouts and misaligned targets.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value driven while reset is high
//  EXC_VECTOR    32'h0000_0080  PC value driven on a misaligned redirect target
//  MAX_WAIT      8              imem wait cycles allowed before timeout (1..255)
// PORTS
//  clock              in   1   system clock, all state updates on posedge
//  reset              in   1   synchronous, active-high reset
//  run                in   1   level enable: start/continue fetching
//  inst_address       in   32  current PC (ProgramCounter output)
//  jump               in   1   jump redirect request
//  jump_target        in   32  jump destination
//  branch_taken       in   1   taken-branch redirect request
//  branch_target      in   32  branch destination
//  stall              in   1   hazard stall: hold PC, no request
//  imem_ready         in   1   imem has data for inst_address this cycle
//  next_inst_address  out  32  combinational next PC to ProgramCounter
//  imem_req           out  1   combinational fetch request for inst_address
//  fetch_valid        out  1   combinational: fetched word accepted this cycle
//  flush              out  1   registered 1-cycle pulse after any redirect
//  misalign_err       out  1   registered 1-cycle pulse, target[1:0]!=0
//  timeout            out  1   registered sticky: imem wait exceeded MAX_WAIT
// BEHAVIOUR
//  Reset:
//  - While reset=1: next_inst_address=RESET_VECTOR; imem_req=0; fetch_valid=0.
//  - On the reset edge: state=IDLE, wait_cnt=0, flush=0, misalign_err=0, timeout=0.
//  - reset overrides every other input, including mid-WAIT.
//  FSM states: IDLE, FETCH, WAIT, HALT.
//  Redirect:
//  - redir = jump|branch_taken; jump has priority; tgt = jump ? jump_target : branch_target.
//  - Legal only in FETCH/WAIT; ignored in IDLE/HALT.
//  - Aligned tgt: next=tgt.
//  - tgt[1:0]!=0: next=EXC_VECTOR; misalign_err=1 for the next cycle.
//  - Either case: fetch_valid=0, flush=1 for the next cycle, wait_cnt=0, state->FETCH.
//  - Redirect beats stall and imem_ready in the same cycle.
//  IDLE:
//  - next=inst_address; imem_req=0; run=1 -> FETCH.
//  FETCH (imem_req = !stall):
//  - redir: handled as above.
//  - stall: next=inst_address, stay FETCH.
//  - imem_ready: fetch_valid=1, next=inst_address+4. run=0 -> IDLE, else stay FETCH.
//  - Otherwise: next=inst_address, wait_cnt=1, ->WAIT.
//  WAIT (imem_req=1; stall ignored; the request stays outstanding):
//  - redir: handled as above.
//  - imem_ready: fetch_valid=1, next=inst_address+4, wait_cnt=0, ->FETCH, or ->IDLE if run=0.
//  - Otherwise: next=inst_address, wait_cnt+1.
//  - wait_cnt==MAX_WAIT and !imem_ready: timeout=1 (sticky), ->HALT.
//  HALT:
//  - next=inst_address; imem_req=0; only reset exits.
//  Arithmetic and timing:
//  - PC+4 is 32-bit modulo: 32'hFFFF_FFFC -> 32'h0000_0000.
//  - wait_cnt is 8 bits.
//  - Zero-latency path: next PC depends combinationally on this cycle's inputs and is
//    loaded by ProgramCounter on the same edge.
// TESTING
//  1 reset=1 two cycles, then run=1, imem_ready=1 -> PC 0,4,8,C. fetch_valid=1 each cycle; flush=0.
//  2 At PC=0x10: imem_ready=0 three cycles, then 1 -> PC holds 0x10 for 3 cycles, then 0x14.
//    imem_req=1 throughout; fetch_valid=1 only on the ready cycle.
//  3 At PC=0x20: jump=1, jump_target=0x100, branch_taken=1, branch_target=0x40, stall=1
//    -> PC=0x100; flush=1 next cycle only; fetch_valid=0.
//  4 branch_target=0x42 -> PC=0x80; misalign_err and flush pulse 1 cycle.
//  5 MAX_WAIT=8, imem_ready held 0 -> timeout=1 after 8 wait cycles; PC frozen; imem_req=0.
//    reset clears timeout; PC=0.
//  6 PC=0xFFFF_FFFC, imem_ready=1 -> PC=0. reset asserted mid-WAIT -> PC=RESET_VECTOR, state IDLE.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: picks next_inst_address from reset vector, redirect, hold or PC+4.
// Zero-latency next-PC path; backpressure via stall/imem_ready holds the PC, flags are registered.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned MAX_WAIT     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] inst_address,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        imem_ready,
  output logic [31:0] next_inst_address,
  output logic        imem_req,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign_err,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HALT} state_t;

  localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        redir, redir_act, tgt_misaligned, timeout_set;
  logic [31:0] tgt, pc_plus4;

  assign redir          = jump | branch_taken;
  assign tgt            = jump ? jump_target : branch_target;
  assign tgt_misaligned = (tgt[1:0] != 2'b00);
  assign pc_plus4       = inst_address + 32'd4;

  always_comb begin
    state_nxt         = state;
    wait_cnt_nxt      = wait_cnt;
    next_inst_address = inst_address;
    imem_req          = 1'b0;
    fetch_valid       = 1'b0;
    redir_act         = 1'b0;
    timeout_set       = 1'b0;

    if (reset) begin
      next_inst_address = RESET_VECTOR;
      state_nxt         = IDLE;
      wait_cnt_nxt      = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (run) state_nxt = FETCH;
        end
        FETCH: begin
          imem_req = !stall;
          if (redir) begin
            redir_act = 1'b1;
          end else if (stall) begin
            state_nxt = FETCH;
          end else if (imem_ready) begin
            fetch_valid       = 1'b1;
            next_inst_address = pc_plus4;
            if (!run) state_nxt = IDLE;
          end else begin
            wait_cnt_nxt = 8'd1;
            state_nxt    = WAIT;
          end
        end
        WAIT: begin
          // The request stays outstanding, so a hazard stall cannot withdraw it.
          imem_req = 1'b1;
          if (redir) begin
            redir_act = 1'b1;
          end else if (imem_ready) begin
            fetch_valid       = 1'b1;
            next_inst_address = pc_plus4;
            wait_cnt_nxt      = 8'd0;
            state_nxt         = run ? FETCH : IDLE;
          end else if (wait_cnt == MAX_WAIT_CNT) begin
            timeout_set = 1'b1;
            state_nxt   = HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
        end
        HALT: begin
          state_nxt = HALT;
        end
        default: state_nxt = IDLE;
      endcase

      if (redir_act) begin
        next_inst_address = tgt_misaligned ? EXC_VECTOR : tgt;
        wait_cnt_nxt      = 8'd0;
        state_nxt         = FETCH;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      flush        <= redir_act;
      misalign_err <= redir_act & tgt_misaligned;
      if (timeout_set) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle expectations queued by stimulus, checked by a negedge monitor.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [31:0] inst_address;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] next_inst_address;
  logic        imem_req, fetch_valid, flush, misalign_err, timeout;

  logic [31:0] pc = 32'h0;
  assign inst_address = pc;

  always #5 clock = ~clock;

  // ProgramCounter stand-in: loads the sequencer's next PC every edge.
  always @(posedge clock) pc <= next_inst_address;

  fetch_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR  (32'h0000_0080),
    .MAX_WAIT    (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .run              (run),
    .inst_address     (inst_address),
    .jump             (jump),
    .jump_target      (jump_target),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .stall            (stall),
    .imem_ready       (imem_ready),
    .next_inst_address(next_inst_address),
    .imem_req         (imem_req),
    .fetch_valid      (fetch_valid),
    .flush            (flush),
    .misalign_err     (misalign_err),
    .timeout          (timeout)
  );

  typedef struct packed {
    int          id;
    logic [31:0] nxt;
    logic        rq;
    logic        fv;
    logic        fl;
    logic        me;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step %0d %s got %h expected %h", id, name, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("next_inst_address", e.id, next_inst_address, e.nxt);
      chk("imem_req",          e.id, {31'd0, imem_req},     {31'd0, e.rq});
      chk("fetch_valid",       e.id, {31'd0, fetch_valid},  {31'd0, e.fv});
      chk("flush",             e.id, {31'd0, flush},        {31'd0, e.fl});
      chk("misalign_err",      e.id, {31'd0, misalign_err}, {31'd0, e.me});
      chk("timeout",           e.id, {31'd0, timeout},      {31'd0, e.to});
    end
  end

  // Inputs are already applied for this cycle; queue what the DUT must show, then advance.
  task automatic cyc(input logic [31:0] nxt, input logic rq, input logic fv,
                     input logic fl, input logic me, input logic to);
    exp_t e;
    step_id++;
    e = '{id: step_id, nxt: nxt, rq: rq, fv: fv, fl: fl, me: me, to: to};
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    // First reset edge establishes register state; it is not checked.
    @(posedge clock);
    #1;

    // 1: reset state, then sequential fetch 0,4,8,C
    cyc(32'h0, 0, 0, 0, 0, 0);
    reset = 0; run = 1; imem_ready = 1;
    cyc(32'h0,  0, 0, 0, 0, 0);
    cyc(32'h4,  1, 1, 0, 0, 0);
    cyc(32'h8,  1, 1, 0, 0, 0);
    cyc(32'hC,  1, 1, 0, 0, 0);
    cyc(32'h10, 1, 1, 0, 0, 0);

    // 2: imem wait at 0x10 for three cycles, then ready
    imem_ready = 0;
    cyc(32'h10, 1, 0, 0, 0, 0);
    cyc(32'h10, 1, 0, 0, 0, 0);
    cyc(32'h10, 1, 0, 0, 0, 0);
    imem_ready = 1;
    cyc(32'h14, 1, 1, 0, 0, 0);
    stall = 1;
    cyc(32'h14, 0, 0, 0, 0, 0);
    stall = 0;
    cyc(32'h18, 1, 1, 0, 0, 0);
    cyc(32'h1C, 1, 1, 0, 0, 0);
    cyc(32'h20, 1, 1, 0, 0, 0);

    // 3: jump beats branch and stall
    jump = 1; jump_target = 32'h100; branch_taken = 1; branch_target = 32'h40; stall = 1;
    cyc(32'h100, 0, 0, 0, 0, 0);
    jump = 0; branch_taken = 0; stall = 0;
    cyc(32'h104, 1, 1, 1, 0, 0);
    cyc(32'h108, 1, 1, 0, 0, 0);

    // 4: misaligned branch target goes to the exception vector
    branch_taken = 1; branch_target = 32'h42;
    cyc(32'h80, 1, 0, 0, 0, 0);
    branch_taken = 0;
    cyc(32'h84, 1, 1, 1, 1, 0);
    cyc(32'h88, 1, 1, 0, 0, 0);

    // redirect while waiting, with stall ignored in WAIT
    imem_ready = 0;
    cyc(32'h88, 1, 0, 0, 0, 0);
    jump = 1; jump_target = 32'h200; stall = 1;
    cyc(32'h200, 1, 0, 0, 0, 0);
    jump = 0; stall = 0;
    cyc(32'h200, 1, 0, 1, 0, 0);

    // 5: eight wait cycles then timeout and halt
    for (int i = 0; i < 8; i++) cyc(32'h200, 1, 0, 0, 0, 0);
    cyc(32'h200, 0, 0, 0, 0, 1);
    imem_ready = 1; jump = 1; jump_target = 32'h300;
    cyc(32'h200, 0, 0, 0, 0, 1);
    jump = 0;
    cyc(32'h200, 0, 0, 0, 0, 1);
    reset = 1;
    cyc(32'h0, 0, 0, 0, 0, 1);
    reset = 0;
    cyc(32'h0, 0, 0, 0, 0, 0);

    // run dropped on an accepted fetch returns to IDLE; redirects ignored there
    run = 0;
    cyc(32'h4, 1, 1, 0, 0, 0);
    cyc(32'h4, 0, 0, 0, 0, 0);
    jump = 1; jump_target = 32'h300;
    cyc(32'h4, 0, 0, 0, 0, 0);
    jump = 0; run = 1;
    cyc(32'h4, 0, 0, 0, 0, 0);

    // 6: PC+4 wraps, then reset mid-WAIT
    jump = 1; jump_target = 32'hFFFF_FFFC;
    cyc(32'hFFFF_FFFC, 1, 0, 0, 0, 0);
    jump = 0;
    cyc(32'h0, 1, 1, 1, 0, 0);
    cyc(32'h4, 1, 1, 0, 0, 0);
    imem_ready = 0;
    cyc(32'h4, 1, 0, 0, 0, 0);
    cyc(32'h4, 1, 0, 0, 0, 0);
    reset = 1; imem_ready = 1;
    cyc(32'h0, 0, 0, 0, 0, 0);
    reset = 0;
    cyc(32'h0, 0, 0, 0, 0, 0);
    cyc(32'h4, 1, 1, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d expectations left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
